// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches two timed workers on one start and pulses
// proceed to the parent with join / join_any / join_none semantics.
module fork_join_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] dur_a,
  input  logic [W-1:0] dur_b,
  input  logic         abort,
  output logic         busy,
  output logic         proceed,
  output logic         a_active,
  output logic         b_active,
  output logic         a_done,
  output logic         b_done,
  output logic         all_done,
  output logic         start_drop,
  output logic [W:0]   elapsed
);

  typedef enum logic [1:0] {IDLE, RUN, DETACHED} state_t;
  typedef enum logic [1:0] {M_JOIN, M_ANY, M_NONE} op_mode_t;

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W:0]   EL_ONE  = (W+1)'(1);
  localparam logic [W:0]   EL_MAX  = '1;

  state_t     state, state_nx;
  op_mode_t   op_mode, mode_in, mode_eff;
  logic [W-1:0] cnt_a, cnt_b;   // remaining active cycles per worker
  logic [W-1:0] da0, db0;
  logic accept, pending;
  logic a_fin, b_fin, a_run, b_run, all_fin, proceed_nx;

  assign busy       = a_active | b_active;
  assign start_drop = start & busy;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    accept   = start && (state == IDLE) && !abort;
    da0      = (dur_a == '0) ? ONE : dur_a;
    db0      = (dur_b == '0) ? ONE : dur_b;
    mode_in  = (mode == 2'd1) ? M_ANY : (mode == 2'd2) ? M_NONE : M_JOIN;
    mode_eff = accept ? mode_in : op_mode;
    a_fin    = 1'b0;
    b_fin    = 1'b0;
    a_run    = 1'b0;
    b_run    = 1'b0;
    if (accept) begin
      a_fin = (da0 == ONE);
      b_fin = (db0 == ONE);
      a_run = !a_fin;
      b_run = !b_fin;
    end else begin
      a_fin = a_active && (cnt_a == ONE);
      b_fin = b_active && (cnt_b == ONE);
      a_run = a_active && !a_fin;
      b_run = b_active && !b_fin;
    end
    all_fin = (a_fin || b_fin) && !a_run && !b_run;
    // pending: the parent is still waiting for its proceed pulse
    pending = accept ? (mode_in != M_NONE) : (state == RUN);
    case (mode_eff)
      M_ANY:   proceed_nx = pending && (a_fin || b_fin);
      M_NONE:  proceed_nx = accept;
      default: proceed_nx = pending && all_fin;
    endcase
    state_nx = IDLE;
    if (accept || state != IDLE) begin
      if (all_fin)                      state_nx = IDLE;
      else if (pending && !proceed_nx)  state_nx = RUN;
      else                              state_nx = DETACHED;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_mode  <= M_JOIN;
      cnt_a    <= '0;
      cnt_b    <= '0;
      a_active <= 1'b0;
      b_active <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      all_done <= 1'b0;
      proceed  <= 1'b0;
      elapsed  <= '0;
    end else if (abort) begin
      // kill everything silently; elapsed keeps the value reached so far
      state    <= IDLE;
      cnt_a    <= '0;
      cnt_b    <= '0;
      a_active <= 1'b0;
      b_active <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      all_done <= 1'b0;
      proceed  <= 1'b0;
    end else begin
      state    <= state_nx;
      a_active <= a_run;
      b_active <= b_run;
      a_done   <= a_fin;
      b_done   <= b_fin;
      all_done <= all_fin;
      proceed  <= proceed_nx;
      if (accept) begin
        op_mode <= mode_in;
        cnt_a   <= da0 - ONE;
        cnt_b   <= db0 - ONE;
        elapsed <= EL_ONE;
      end else begin
        if (a_active) cnt_a <= cnt_a - ONE;
        if (b_active) cnt_b <= cnt_b - ONE;
        if (busy && elapsed != EL_MAX) elapsed <= elapsed + EL_ONE;
      end
    end
  end

endmodule
